// File: rtl/aes_pkg.sv
// Types, constants and GF(2^8) helpers shared by the iterative AES-128 encryptor.
// State bytes are FIPS-197 column-major: byte n = 4*col + row sits at [127-8n -: 8].
package aes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam int unsigned NR = 10;
    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] rcon(logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) return RCON[r - 4'd1];
        return 8'h00;
    endfunction

    function automatic int unsigned bpos(int unsigned col, int unsigned row);
        return 127 - 8 * (4 * col + row);
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] mixcolumn(logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] shift_rows(logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned w = 0; w < 4; w++) begin
                r[bpos(c, w) -: 8] = s[bpos((c + w) % 4, w) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_enc_iter_if.sv
// Block/result handshake bundle between a plaintext source and the AES-128 encryptor.
interface aes128_enc_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plain;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cipher;
    logic [127:0] last_key;

    modport master (
        output in_valid, plain, key, out_ready,
        input  in_ready, out_valid, cipher, last_key
    );

    modport slave (
        input  in_valid, plain, key, out_ready,
        output in_ready, out_valid, cipher, last_key
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8) (as a^254)
// followed by the FIPS-197 affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    logic [7:0] sq;
    logic [7:0] inv;

    // a^254 = a^2 * a^4 * ... * a^128; zero maps to zero as required.
    always_comb begin
        sq  = a_i;
        inv = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion;
// exports the round-10 key alongside the ciphertext for a downstream decryptor.
module aes128_enc_iter
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    aes128_enc_iter_if.slave  bus
);
    fsm_e         fsm_q, fsm_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [127:0] sub_st, sr, mc, round_st, rk_next;
    logic [31:0]  rot_w, sub_w, tmp_w;
    logic [31:0]  w0, w1, w2, w3;
    logic         in_ready, accept;

    for (genvar i = 0; i < 16; i++) begin : g_sb_state
        aes_sbox u_sbox (.a_i(st_q[127-8*i -: 8]), .s_o(sub_st[127-8*i -: 8]));
    end

    assign rot_w = {rk_q[23:0], rk_q[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sb_key
        aes_sbox u_sbox (.a_i(rot_w[31-8*j -: 8]), .s_o(sub_w[31-8*j -: 8]));
    end

    always_comb begin
        tmp_w   = sub_w ^ {rcon(rnd_q), 24'h000000};
        w0      = rk_q[127:96] ^ tmp_w;
        w1      = rk_q[95:64]  ^ w0;
        w2      = rk_q[63:32]  ^ w1;
        w3      = rk_q[31:0]   ^ w2;
        rk_next = {w0, w1, w2, w3};
    end

    always_comb begin
        sr = shift_rows(sub_st);
        mc = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = mixcolumn(sr[127 - 32*c -: 32]);
        end
        round_st = ((rnd_q == 4'(NR)) ? sr : mc) ^ rk_next;
    end

    assign in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        rk_d  = rk_q;
        rnd_d = rnd_q;
        unique case (fsm_q)
            IDLE: ;
            RUN: begin
                st_d  = round_st;
                rk_d  = rk_next;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'(NR)) fsm_d = DONE;
            end
            DONE:    if (bus.out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
        // Accept overrides the DONE->IDLE exit so a new block loads in the consume cycle.
        if (accept) begin
            st_d  = bus.plain ^ bus.key;
            rk_d  = bus.key;
            rnd_d = 4'd1;
            fsm_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            rk_q  <= '0;
            rnd_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            rk_q  <= rk_d;
            rnd_q <= rnd_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.cipher    = st_q;
    assign bus.last_key  = rk_q;

endmodule

// File: doc/aes128_enc_iter.md
# aes128_enc_iter

Iterative AES-128 encryption core: one round per clock, on-the-fly key expansion. It produces 128-bit ciphertext from a 128-bit plaintext and a 128-bit cipher key. It is the transmit-side counterpart to the team's iterative AES-128 decryption datapath. Besides the ciphertext, it exports the final (round-10) key so a downstream decryptor can run its inverse key schedule without storing a fixed key table.

## Interface
Parameters:
- none; the block is fixed at AES-128 (Nk=4, Nr=10).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset; assertion clears all state immediately.
- `in_valid`  in  1  plaintext and key presented.
- `in_ready`  out  1  core can accept a block this cycle.
- `plain`  in  128  plaintext; FIPS-197 order, [127:120] = byte 0, column-major.
- `key`  in  128  cipher key, same byte order.
- `out_valid`  out  1  `cipher` and `last_key` valid.
- `out_ready`  in  1  downstream consumes the result.
- `cipher`  out  128  ciphertext.
- `last_key`  out  128  round-10 expanded key.

## Operation
- FSM states:
  - `IDLE`: waits for a block.
  - `RUN`: executes rounds 1..10.
  - `DONE`: holds the result until it is consumed.
- `in_ready` = (`IDLE`) or (`DONE` and `out_ready`). This is combinational, so a new block can be accepted in the same cycle the previous result is consumed.
- Accept (`in_valid` & `in_ready`):
  - state register ← `plain` ^ `key`.
  - round-key register ← `key`.
  - round counter `rnd` ← 1.
  - FSM → `RUN`.
- `RUN`, each cycle:
  - Next round key: rk' = expand(rk, RCON[rnd]). This uses RotWord, SubWord and the RCON XOR on word 3, then a chained XOR across words 0..3.
  - State update: state ← MixColumns(ShiftRows(SubBytes(state))) ^ rk'.
  - Round 10 omits MixColumns.
  - rk ← rk'; `rnd` increments.
- After round 10 is written: FSM → `DONE`, `out_valid`=1.
- `cipher` and `last_key` are the state and rk registers, and stay stable while `out_valid` is high.
- `DONE` with `out_ready`=1:
  - With a simultaneous accept: FSM → `RUN` with the new block loaded.
  - Otherwise: FSM → `IDLE`.
- `in_valid`, `plain` and `key` are ignored while `in_ready`=0, so no block is dropped or corrupted.
- RCON = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- Arithmetic is GF(2^8) with xtime reduction polynomial 0x11b. All XORs are 128-bit with no carries.

## Timing
- Reset values:
  - FSM `IDLE`, `rnd`=0.
  - `in_ready`=1, `out_valid`=0.
  - `cipher`=0, `last_key`=0.
- Latency: accept at edge k gives round 1 at edge k+1 and round 10 at edge k+10. `out_valid` is high in the cycle after edge k+10.
- Throughput: one block per 11 cycles when `out_ready` is held high (back-to-back accept in `DONE`).
- `out_valid` falls at the edge where `out_ready` is sampled high, unless a new block was accepted in the same cycle. In that case it still falls, and rises again 10 edges later.
- If `rst` is asserted mid-`RUN` or in `DONE`:
  - Everything clears asynchronously; the partial result is discarded.
  - After deassertion the core is in `IDLE` with `in_ready`=1 on the next cycle.
- `out_ready` low in `DONE`: the core holds indefinitely and `in_ready`=0.

## Structure
- Package `aes_pkg` holds:
  - FSM enum (`IDLE`/`RUN`/`DONE`).
  - RCON constant array.
  - `xtime` and `mixcolumn` functions.
  - ShiftRows byte-permutation function.
  - Byte-index helpers for column-major order.
- Sub-module `aes_sbox` is a combinational forward S-box, 8-bit in and 8-bit out. It is instantiated 20 times: 16 for the state and 4 for the key-schedule SubWord.
- The top-level datapath is the state register, the round-key register, a 4-bit `rnd` counter and the FSM.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plain 00112233445566778899aabbccddeeff.
  - Required: `cipher`=69c4e0d86a7b0430d8cdb78070b4c55a and `last_key`=13111d7fe3944a17f307a78b4d2b30c5.
  - `out_valid` rises exactly 10 edges after the accept edge.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plain 3243f6a8885a308d313198a2e0370734.
  - Required: `cipher`=3925841d02dc09fbdc118597196a0b32.
- All-zero key and plaintext.
  - Required: `cipher`=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles after `out_valid`. Required: `cipher` stays stable, `in_ready`=0, and a pulsed `in_valid` with a different block has no effect.
  - Then release `out_ready`. Required: it is consumed in exactly one cycle.
- Back-to-back: drive vector C.1 then vector B with `out_ready`=1 and `in_valid` held.
  - Required: the second block is accepted in the `DONE` cycle and both ciphertexts are correct, 11 cycles apart.
- Reset mid-round: assert `rst`=0 at round 5.
  - Required: immediately `out_valid`=0, `in_ready`=1, `cipher`=0.
  - Then re-run C.1. Required: a correct result with 10-cycle latency.
